// File: rtl/fifo_switch_ctrl.sv
// Switch/button front end: synchronizes and debounces the inputs and runs a
// small FIFO whose state feeds the seven-segment display controller.
module fifo_switch_ctrl #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int DB_CYCLES = 50000
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic [3:0]    sw,
    input  logic          btn_push,
    input  logic          btn_pop,
    input  logic          btn_mode,
    output logic [3:0]    input_data,
    output logic [3:0]    output_data,
    output logic          display_mode,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [2:0]  btn_s;
    logic [2:0]  btn_sync1_r;
    logic [2:0]  btn_sync2_r;
    logic [2:0]  level_r;
    logic [2:0]  pulse_r;
    logic [15:0] db_cnt_r [3];
    logic [3:0]  sw_sync1_r;
    logic [3:0]  sw_sync2_r;

    logic [3:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [3:0]    output_data_r;
    logic          mode_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Bit order within the button vectors: 0 = push, 1 = pop, 2 = mode.
    assign btn_s = {btn_mode, btn_pop, btn_push};

    // Input synchronizers, per-button debounce counters and rising-edge pulses.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            btn_sync1_r <= 3'b000;
            btn_sync2_r <= 3'b000;
            level_r     <= 3'b000;
            pulse_r     <= 3'b000;
            sw_sync1_r  <= 4'h0;
            sw_sync2_r  <= 4'h0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= 16'd0;
            end
        end else begin
            btn_sync1_r <= btn_s;
            btn_sync2_r <= btn_sync1_r;
            sw_sync1_r  <= sw;
            sw_sync2_r  <= sw_sync1_r;
            for (int i = 0; i < 3; i++) begin
                pulse_r[i] <= 1'b0;
                if (btn_sync2_r[i] == level_r[i]) begin
                    db_cnt_r[i] <= 16'd0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    // Level flips here; only a flip to 1 produces a pulse.
                    level_r[i]  <= ~level_r[i];
                    db_cnt_r[i] <= 16'd0;
                    pulse_r[i]  <= ~level_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    // Qualify push/pop; a pop frees a slot, so push on a full FIFO is allowed alongside it.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pulse_r[1] && (count_r != '0)) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (pulse_r[0] && ((count_r != DEPTH_CNT) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // FIFO storage write port (storage is intentionally not reset).
    always_ff @(posedge clk_in) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= sw_sync2_r;
        end
    end

    // Pointers, occupancy, popped data and display mode.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            output_data_r <= 4'h0;
            mode_r        <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                output_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r      <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (pulse_r[2]) begin
                mode_r <= ~mode_r;
            end
        end
    end

    assign input_data   = sw_sync2_r;
    assign output_data  = output_data_r;
    assign display_mode = mode_r;
    assign count        = count_r;
    assign empty        = (count_r == '0);
    assign full         = (count_r == DEPTH_CNT);

endmodule

// File: tb/tb_fifo_switch_ctrl.sv
// Self-checking bench for fifo_switch_ctrl with a short debounce window; a
// reference FIFO model feeds a queue of expected popped values.
module tb_fifo_switch_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_push;
    logic       btn_pop;
    logic       btn_mode;
    logic [3:0] input_data;
    logic [3:0] output_data;
    logic       display_mode;
    logic       empty;
    logic       full;
    logic [3:0] count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] mq[$];
    logic [3:0] exp_q[$];
    logic [3:0] last_out = 4'h0;
    logic       mode_exp = 1'b0;

    fifo_switch_ctrl #(.DEPTH(8), .AW(3), .DB_CYCLES(4)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .sw          (sw),
        .btn_push    (btn_push),
        .btn_pop     (btn_pop),
        .btn_mode    (btn_mode),
        .input_data  (input_data),
        .output_data (output_data),
        .display_mode(display_mode),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, "_full"},  32'(full),  32'(mq.size() == 8));
    endtask

    // One button action: p = push, q = pop, with switches at v.
    task automatic op(input logic p, input logic q, input logic [3:0] v);
        logic popped;
        logic pushed;
        sw = v;
        tick(3);
        popped = q && (mq.size() > 0);
        pushed = p && ((mq.size() < 8) || popped);
        if (popped) last_out = mq.pop_front();
        if (pushed) mq.push_back(v);
        if (q) exp_q.push_back(last_out);
        btn_push = p;
        btn_pop  = q;
        tick(20);
        btn_push = 1'b0;
        btn_pop  = 1'b0;
        tick(10);
        check("input_data", 32'(input_data), 32'(v));
        check_state("op");
        if (q) check("pop_data", 32'(output_data), 32'(exp_q.pop_front()));
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(20);
        btn_mode = 1'b0;
        tick(10);
        mode_exp = ~mode_exp;
        check("display_mode", 32'(display_mode), 32'(mode_exp));
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        mq.delete();
        exp_q.delete();
        last_out = 4'h0;
        mode_exp = 1'b0;
        check("rst_out", 32'(output_data), 32'h0);
        check("rst_mode", 32'(display_mode), 32'h0);
        check("rst_in", 32'(input_data), 32'h0);
        check_state("rst");
        btn_push = 1'b0;
        btn_pop  = 1'b0;
        btn_mode = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [3:0] vals [8] = '{4'h3, 4'h7, 4'h9, 4'hA, 4'hC, 4'h1, 4'h2, 4'h8};
        rst = 1'b1; sw = 4'h0; btn_push = 1'b0; btn_pop = 1'b0; btn_mode = 1'b0;
        tick(3);
        do_reset();

        // Reset mid-press discards the press and clears all state.
        op(1'b1, 1'b0, 4'h3);
        press_mode();
        btn_push = 1'b1;
        tick(4);
        do_reset();
        tick(20);
        check_state("after_midpress");

        // Single push held long, then pop.
        op(1'b1, 1'b0, 4'h5);
        op(1'b0, 1'b1, 4'h0);

        // Fill, overflow, drain, underflow.
        foreach (vals[i]) op(1'b1, 1'b0, vals[i]);
        op(1'b1, 1'b0, 4'hF);
        for (int i = 0; i < 9; i++) op(1'b0, 1'b1, 4'h0);

        // Pointer wrap from index 5 across 7 -> 0.
        do_reset();
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 4'(i + 1));
        for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 6; i++) op(1'b1, 1'b0, 4'(i + 10));
        for (int i = 0; i < 6; i++) op(1'b0, 1'b1, 4'h0);

        // Short glitch on pop is rejected.
        op(1'b1, 1'b0, 4'h4);
        btn_pop = 1'b1;
        tick(2);
        btn_pop = 1'b0;
        tick(12);
        check_state("glitch");
        check("glitch_out", 32'(output_data), 32'(last_out));
        op(1'b0, 1'b1, 4'h0);

        // Simultaneous push and pop: empty, then full.
        op(1'b1, 1'b1, 4'h6);
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 4'(i + 7));
        op(1'b1, 1'b1, 4'hE);
        for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 4'h0);

        press_mode();
        press_mode();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
